// File: rtl/bus_pkg.sv
// Shared types and constants for the memory bus interconnect.
// Default bus shape plus the command, read-tag and arbiter-state types.
package bus_pkg;

    localparam int BUS_N_MST  = 2;
    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;
    localparam int MAX_MST    = 8;
    localparam int LOCK_WDOG  = 16;
    localparam int WDOG_W     = $clog2(LOCK_WDOG);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag index is sized for the largest supported requester count
    localparam int MST_IDX_W = idx_w(MAX_MST);

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_cmd_t;

    typedef struct packed {
        logic                 valid;
        logic [MST_IDX_W-1:0] idx;
    } rd_tag_t;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a per-requester bus lock and lock watchdog.
// Grant is combinational; the search pointer and lock owner are registered.
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  lock_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] win_o
);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [N-1:0]      owner_q, owner_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    logic [N-1:0]      rr_mask, rr_hi, rr_pool, rr_gnt;
    logic [IW-1:0]     rr_idx, own_idx;
    logic              own_req, own_lock;

    function automatic logic [IW-1:0] oh2idx(input logic [N-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (oh[j]) r = r | IW'(j);
        end
        return r;
    endfunction

    // Requesters above the last winner take precedence, then wrap around
    always_comb begin
        rr_mask = '0;
        for (int j = 0; j < N; j++) begin
            rr_mask[j] = (IW'(j) > last_q);
        end
    end

    assign rr_hi    = req_i & rr_mask;
    assign rr_pool  = (|rr_hi) ? rr_hi : req_i;
    assign rr_gnt   = rr_pool & (~rr_pool + N'(1));
    assign rr_idx   = oh2idx(rr_gnt);
    assign own_idx  = oh2idx(owner_q);
    assign own_req  = |(req_i & owner_q);
    assign own_lock = |(lock_i & owner_q);
    assign win_o    = oh2idx(gnt_o);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        wdog_d  = wdog_q;
        gnt_o   = '0;
        unique case (state_q)
            ST_OPEN: begin
                gnt_o = rr_gnt;
                if (|rr_gnt) begin
                    last_d = rr_idx;
                    if (|(lock_i & rr_gnt)) begin
                        state_d = ST_LOCKED;
                        owner_d = rr_gnt;
                        wdog_d  = '0;
                    end
                end
            end
            ST_LOCKED: begin
                gnt_o = req_i & owner_q;
                if (own_req) begin
                    last_d = own_idx;
                    wdog_d = '0;
                    if (!own_lock) state_d = ST_OPEN;
                end else if (wdog_q == WDOG_W'(LOCK_WDOG - 1)) begin
                    state_d = ST_OPEN;
                    last_d  = own_idx;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: ;
        endcase
        if (rst_i) gnt_o = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_OPEN;
            last_q  <= IW'(N - 1);
            owner_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared single-port RAM interconnect: arbitration, registered command
// stage and a read-tag pipe that steers returning data to its requester.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_MST  = BUS_N_MST,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_MST-1:0]         req_i,
    input  logic [N_MST-1:0]         lock_i,
    input  logic [N_MST-1:0]         we_i,
    input  logic [N_MST*ADDR_W-1:0]  addr_i,
    input  logic [N_MST*DATA_W-1:0]  wdata_i,
    output logic [N_MST-1:0]         gnt_o,
    output logic [N_MST-1:0]         rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic [DATA_W-1:0]        mem_rdata_i
);

    localparam int IW = idx_w(N_MST);

    logic [N_MST-1:0] gnt;
    logic [IW-1:0]    win;
    logic             xfer;
    bus_cmd_t         cmd_d, cmd_q;
    logic             en_q;
    rd_tag_t          tag_d;
    rd_tag_t          tag_q [RD_LAT+1];

    rr_arbiter #(
        .N  (N_MST),
        .IW (IW)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .lock_i (lock_i),
        .gnt_o  (gnt),
        .win_o  (win)
    );

    assign gnt_o = gnt;
    assign xfer  = |gnt;

    // Address and write data hold their last value when idle
    always_comb begin
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        for (int k = 0; k < N_MST; k++) begin
            if (gnt[k]) begin
                cmd_d.we    = we_i[k];
                cmd_d.addr  = addr_i[k*ADDR_W +: ADDR_W];
                cmd_d.wdata = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        tag_d       = '0;
        tag_d.valid = xfer & ~cmd_d.we;
        tag_d.idx   = MST_IDX_W'(win);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q <= '0;
            en_q  <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            cmd_q    <= cmd_d;
            en_q     <= xfer;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < N_MST; k++) begin
            rvalid_o[k] = tag_q[RD_LAT].valid &&
                          (tag_q[RD_LAT].idx == MST_IDX_W'(k));
        end
    end

    assign rdata_o     = mem_rdata_i;
    assign mem_en_o    = en_q;
    assign mem_we_o    = cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with RD_LAT=1 and RD_LAT=3 instances
// sharing one requester stimulus, each backed by a small RAM model.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req, lock, we;
    logic [31:0] addr;
    logic [15:0] wdata;

    logic [1:0]  gnt1, gnt3, rv1, rv3;
    logic [7:0]  rd1, rd3, mwd1, mwd3, mrd1, mrd3;
    logic        en1, en3, mwe1, mwe3;
    logic [15:0] maddr1, maddr3;

    logic [7:0]  ram1 [256];
    logic [7:0]  ram3 [256];
    logic [7:0]  rp1;
    logic [7:0]  rp3 [3];

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.N_MST(2), .ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1),
        .rdata_o(rd1), .mem_en_o(en1), .mem_we_o(mwe1),
        .mem_addr_o(maddr1), .mem_wdata_o(mwd1), .mem_rdata_i(mrd1)
    );

    mem_bus_arbiter #(.N_MST(2), .ADDR_W(16), .DATA_W(8), .RD_LAT(3)) u3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt3), .rvalid_o(rv3),
        .rdata_o(rd3), .mem_en_o(en3), .mem_we_o(mwe3),
        .mem_addr_o(maddr3), .mem_wdata_o(mwd3), .mem_rdata_i(mrd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents start as addr ^ 0x3C
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram1[i] <= 8'(i) ^ 8'h3C;
        end else if (en1) begin
            if (mwe1) ram1[maddr1[7:0]] <= mwd1;
            else      rp1 <= ram1[maddr1[7:0]];
        end
    end

    always @(posedge clk) begin
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
        if (rst) begin
            for (int i = 0; i < 256; i++) ram3[i] <= 8'(i) ^ 8'h3C;
        end else if (en3) begin
            if (mwe3) ram3[maddr3[7:0]] <= mwd3;
            else      rp3[0] <= ram3[maddr3[7:0]];
        end
    end

    assign mrd1 = rp1;
    assign mrd3 = rp3[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] e;
        rst = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        #1;
        rst = 1'b1;
        req = 2'b11;
        tick();
        tick();
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_gnt3", 32'(gnt3), 0);
        chk("rst_en1", 32'(en1), 0);
        chk("rst_en3", 32'(en3), 0);
        chk("rst_we1", 32'(mwe1), 0);
        chk("rst_we3", 32'(mwe3), 0);
        chk("rst_addr1", 32'(maddr1), 0);
        chk("rst_addr3", 32'(maddr3), 0);
        chk("rst_wd1", 32'(mwd1), 0);
        chk("rst_wd3", 32'(mwd3), 0);
        chk("rst_rv1", 32'(rv1), 0);
        chk("rst_rv3", 32'(rv3), 0);
        rst = 1'b0;
        #1;
        chk("first_gnt", 32'(gnt1), 32'h1);
        req = '0;

        // single requester: write then read back
        tick();
        req = 2'b01; we = 2'b01; addr[15:0] = 16'h1234; wdata[7:0] = 8'hA5;
        #1;
        chk("wr_gnt", 32'(gnt1), 32'h1);
        tick();
        chk("wr_en", 32'(en1), 1);
        chk("wr_we", 32'(mwe1), 1);
        chk("wr_addr", 32'(maddr1), 32'h1234);
        chk("wr_wd", 32'(mwd1), 32'hA5);
        we = 2'b00;
        #1;
        chk("rd_gnt", 32'(gnt1), 32'h1);
        tick();
        chk("rd_en", 32'(en1), 1);
        chk("rd_we", 32'(mwe1), 0);
        chk("rd_addr", 32'(maddr1), 32'h1234);
        chk("rd_rv_early", 32'(rv1), 0);
        req = '0;
        tick();
        chk("idle_en", 32'(en1), 0);
        chk("idle_we", 32'(mwe1), 0);
        chk("hold_addr", 32'(maddr1), 32'h1234);
        chk("hold_wd", 32'(mwd1), 32'hA5);
        chk("rd1_rv", 32'(rv1), 32'h1);
        chk("rd1_data", 32'(rd1), 32'hA5);
        chk("rd3_early", 32'(rv3), 0);
        tick();
        chk("rd1_rv_off", 32'(rv1), 0);
        tick();
        chk("rd3_rv", 32'(rv3), 32'h1);
        chk("rd3_data", 32'(rd3), 32'hA5);

        // lock by requester 1 for 3 transfers, then round-robin
        tick();
        for (int i = 0; i < 9; i++) begin
            req  = (i < 7) ? 2'b11 : 2'b00;
            lock = (i < 2) ? 2'b10 : 2'b00;
            we   = 2'b00;
            addr = {16'h0020, 16'h0010};
            #1;
            if (i < 3)      e = 2'b10;
            else if (i < 7) e = (i % 2 == 1) ? 2'b01 : 2'b10;
            else            e = 2'b00;
            chk($sformatf("lk_gnt%0d", i), 32'(gnt1), 32'(e));
            if (i < 2)      e = 2'b00;
            else if (i < 5) e = 2'b10;
            else            e = (i % 2 == 1) ? 2'b01 : 2'b10;
            chk($sformatf("lk_rv%0d", i), 32'(rv1), 32'(e));
            if (e == 2'b10) chk($sformatf("lk_rd%0d", i), 32'(rd1), 32'h1C);
            if (e == 2'b01) chk($sformatf("lk_rd%0d", i), 32'(rd1), 32'h2C);
            tick();
        end

        // alternating back-to-back reads of 0x0000..0x0003
        for (int j = 0; j < 8; j++) begin
            req = (j < 4) ? 2'b11 : 2'b00;
            addr[15:0]  = (j >= 1) ? 16'h0002 : 16'h0000;
            addr[31:16] = (j >= 2) ? 16'h0003 : 16'h0001;
            #1;
            if (j < 4) begin
                e = (j % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("b2b_gnt%0d", j), 32'(gnt3), 32'(e));
            end
            if (j >= 2 && j < 6) begin
                e = (j % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("b2b_rv1_%0d", j), 32'(rv1), 32'(e));
                chk($sformatf("b2b_rd1_%0d", j), 32'(rd1), 32'h3A + 32'(j));
            end
            if (j >= 4) begin
                e = (j % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("b2b_rv3_%0d", j), 32'(rv3), 32'(e));
                chk($sformatf("b2b_rd3_%0d", j), 32'(rd3), 32'h38 + 32'(j));
            end
            tick();
        end

        // reset one cycle after a read grant drops the read
        req = 2'b01; we = 2'b00; addr[15:0] = 16'h0000;
        #1;
        chk("drop_gnt", 32'(gnt3), 32'h1);
        tick();
        rst = 1'b1;
        req = 2'b11;
        #1;
        chk("mid_rst_gnt", 32'(gnt1), 0);
        chk("mid_rst_en", 32'(en1), 0);
        chk("mid_rst_rv3", 32'(rv3), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_prio", 32'(gnt3), 32'h1);
        chk("drop_rv1", 32'(rv1), 0);
        req = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("drop_rv1_%0d", k), 32'(rv1), 0);
            chk($sformatf("drop_rv3_%0d", k), 32'(rv3), 0);
        end

        // lock watchdog: owner goes idle for 16 cycles
        tick();
        req = 2'b10; lock = 2'b10; we = 2'b00;
        #1;
        chk("wd_gnt0", 32'(gnt1), 32'h2);
        tick();
        req = 2'b01; lock = 2'b00;
        #1;
        chk("wd_stall", 32'(gnt1), 0);
        repeat (15) tick();
        chk("wd_still", 32'(gnt1), 0);
        tick();
        chk("wd_release", 32'(gnt1), 32'h1);
        req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised shared-memory bus interconnect that lets N_MST requesters (core, DMA, debug port) share one single-port synchronous RAM. It replaces the point-to-point core-to-RAM wiring in the top level. It provides round-robin arbitration with an optional bus lock for atomic read-modify-write sequences. It registers the winning command toward the RAM and routes read data back to the issuing requester with a per-requester valid strobe.

## Interface
Parameters:
- N_MST, 2: number of requesters, 1..8
- ADDR_W, 16: address width
- DATA_W, 8: data width
- RD_LAT, 1: RAM read latency in cycles from the sampling edge, 1..4

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_i  in  N_MST  per-requester access request
- lock_i  in  N_MST  per-requester bus lock; honoured only while that requester holds the grant
- we_i  in  N_MST  per-requester write enable; 1 = write, 0 = read
- addr_i  in  N_MST*ADDR_W  packed addresses; requester k occupies bits [k*ADDR_W +: ADDR_W]
- wdata_i  in  N_MST*DATA_W  packed write data
- gnt_o  out  N_MST  one-hot grant, combinational, same cycle as the request
- rvalid_o  out  N_MST  one-hot read-data valid, registered
- rdata_o  out  DATA_W  read data, broadcast to all requesters; qualify with rvalid_o
- mem_en_o  out  1  RAM access strobe, registered
- mem_we_o  out  1  RAM write enable, registered
- mem_addr_o  out  ADDR_W  RAM address, registered
- mem_wdata_o  out  DATA_W  RAM write data, registered
- mem_rdata_i  in  DATA_W  RAM read data

## Operation
- **Arbitration.** Each cycle at most one gnt_o bit is set, and only for a requester with req_i high. A transfer completes when req_i[k] & gnt_o[k] is high at a rising edge.
- **Round-robin search.** The search starts at index (last_winner+1) mod N_MST. After reset, last_winner = N_MST-1, so requester 0 has first priority.
- **Lock.** If the current winner transfers with lock_i[k]=1, the arbiter enters LOCKED(k). While locked, only requester k can be granted. gnt_o[k] follows req_i[k] and other requests stall.
- **Lock release.** LOCKED exits on the first transfer by k with lock_i[k]=0; that transfer is still granted. LOCKED also exits if req_i[k]=0 for 16 consecutive cycles (watchdog), and last_winner is set to k.
- **Command stage.** On a transfer edge, the winner's we/addr/wdata are registered into mem_*, and mem_en_o=1 for exactly one cycle per transfer. With no transfer, mem_en_o=0 and mem_we_o=0; mem_addr_o and mem_wdata_o hold their last values.
- **Read tags.** Reads push the winner index plus a valid bit into a tag shift register of depth RD_LAT+1. Writes push an invalid tag.
- **Read return.** rvalid_o[k] is set in exactly the cycle mem_rdata_i carries k's data, and rdata_o = mem_rdata_i (pass-through).
- **Throughput.** One transfer per cycle, back-to-back, any read/write mix. There is no write-to-read hazard logic: the RAM orders accesses.
- **Reset.** Reset at any time clears the tag pipe, LOCKED state and last_winner. In-flight reads are dropped and never produce rvalid_o.

## Timing
- Request at cycle t, granted: gnt_o high in cycle t.
- mem_* valid in cycle t+1; the RAM samples at the end of t+1.
- Read data and rvalid_o[k] are high in cycle t+1+RD_LAT. Total read latency is RD_LAT+1 cycles from the grant edge.
- Writes complete at the end of cycle t+1 and produce no response.
- Reset values: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rvalid_o=0. gnt_o=0 while rst_i is high.
- Simultaneous lock release and another requester's request: the other requester is granted the following cycle, not the same cycle.

## Structure
- Package bus_pkg holds:
  - MST_IDX_W = $clog2(N_MST) (minimum 1)
  - typedef bus_cmd_t {we, addr, wdata}
  - typedef rd_tag_t {valid, idx}
  - LOCK_WDOG = 16
- Sub-module rr_arbiter: N-bit round-robin arbiter with lock input and one-hot grant output. The tag pipe and command register stay in mem_bus_arbiter.

## Test plan
- Reset: drive rst_i high mid-cycle with all req_i high -> all outputs 0 asynchronously; after release, requester 0 is granted first.
- Single requester 0, RD_LAT=1: write 0xA5 to 0x1234, then read 0x1234 -> mem_en_o pulses twice; rvalid_o=01 with rdata_o=0xA5 exactly 2 cycles after the read grant.
- Both requesters request continuously, no lock -> gnt_o sequence 01,10,01,10; each requester receives only its own rvalid_o.
- Requester 1 holds lock_i for 3 transfers while requester 0 requests -> gnt_o=10 for 3 cycles, then 01 after the unlocking transfer.
- RD_LAT=3: 4 back-to-back reads alternating requesters to 0x0000..0x0003 -> rvalid_o alternates 01,10,01,10 starting 4 cycles after the first grant, with data in address order.
- Assert reset one cycle after a read grant -> no rvalid_o after release; lock watchdog releases after 16 idle cycles.
